// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX stage: forwarding select codes, the zero
// register index and the packed control bundle carried through the stage register.
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, downstream write-back hints and registered EX outputs
// for the ID/EX stage; master drives the ID side, slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 3
);
  logic                flush_i;
  logic [DATA_W-1:0]   DataOne_ID, DataTwo_ID, Imm_ID;
  logic [REG_AW-1:0]   Rs_ID, Rt_ID, Rd_ID;
  logic                UsesRt_ID;
  logic                RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID;
  logic [ALUCTL_W-1:0] ALUControl_ID;
  logic                RegWrite_Mem;
  logic [REG_AW-1:0]   WriteReg_Mem;
  logic                RegWrite_Wb;
  logic [REG_AW-1:0]   WriteReg_Wb;
  logic [DATA_W-1:0]   WriteData_Reg;

  logic [DATA_W-1:0]   DataOne_Ex, DataTwo_Ex, Imm_Ex;
  logic [REG_AW-1:0]   WriteReg_Ex;
  logic                RegWrite_Ex, MemtoReg_Ex, MemRead_Ex, MemWrite_Ex, ALUSrc_Ex;
  logic [ALUCTL_W-1:0] ALUControl_Ex;
  logic [1:0]          FA, FB;
  logic                Valid_Ex;
  logic                stall_o;

  modport master (
    output flush_i, DataOne_ID, DataTwo_ID, Imm_ID, Rs_ID, Rt_ID, Rd_ID, UsesRt_ID,
           RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID,
           ALUControl_ID, RegWrite_Mem, WriteReg_Mem, RegWrite_Wb, WriteReg_Wb, WriteData_Reg,
    input  DataOne_Ex, DataTwo_Ex, Imm_Ex, WriteReg_Ex, RegWrite_Ex, MemtoReg_Ex,
           MemRead_Ex, MemWrite_Ex, ALUSrc_Ex, ALUControl_Ex, FA, FB, Valid_Ex, stall_o
  );

  modport slave (
    input  flush_i, DataOne_ID, DataTwo_ID, Imm_ID, Rs_ID, Rt_ID, Rd_ID, UsesRt_ID,
           RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID,
           ALUControl_ID, RegWrite_Mem, WriteReg_Mem, RegWrite_Wb, WriteReg_Wb, WriteData_Reg,
    output DataOne_Ex, DataTwo_Ex, Imm_Ex, WriteReg_Ex, RegWrite_Ex, MemtoReg_Ex,
           MemRead_Ex, MemWrite_Ex, ALUSrc_Ex, ALUControl_Ex, FA, FB, Valid_Ex, stall_o
  );
endinterface

// File: rtl/fwd_sel.sv
// Priority comparator producing one operand's forwarding select: the instruction
// now in EX (next in MEM) wins over the one now in EX/MEM (next in WB); $0 never forwards.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_write,
  output logic [1:0]        sel
);
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  always_comb begin
    sel = FWD_REG;
    if (src != ZERO) begin
      if (ex_write && (ex_dest == src))
        sel = FWD_MEM;
      else if (mem_write && (mem_dest == src))
        sel = FWD_WB;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered forwarding selects and load-use stall.
// Define ID_WB_BYPASS_EN to bypass the WB result into the operands on a same-cycle write/read.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 3
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  ctrl_t               ctrl_p0, ctrl_p1;
  logic [REG_AW-1:0]   dest_p0, dest_p1;
  logic [1:0]          fa_p0, fb_p0, fa_p1, fb_p1;
  logic [ALUCTL_W-1:0] alu_p1;
  logic [DATA_W-1:0]   op_a_p0, op_b_p0, op_a_p1, op_b_p1, imm_p1;
  logic                vld_p1;
  logic                stall, bubble;

  // ---- ID: decode destination, hazards and forwarding selects ----
  assign ctrl_p0 = '{reg_write:  bus.RegWrite_ID,
                     mem_to_reg: bus.MemtoReg_ID,
                     mem_read:   bus.MemRead_ID,
                     mem_write:  bus.MemWrite_ID,
                     alu_src:    bus.ALUSrc_ID};
  assign dest_p0 = bus.RegDst_ID ? bus.Rd_ID : bus.Rt_ID;

  assign stall  = vld_p1 & ctrl_p1.mem_read & (dest_p1 != ZERO) &
                  ((dest_p1 == bus.Rs_ID) | (bus.UsesRt_ID & (dest_p1 == bus.Rt_ID)));
  assign bubble = bus.flush_i | stall;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs (
    .src(bus.Rs_ID), .ex_dest(dest_p1), .ex_write(ctrl_p1.reg_write),
    .mem_dest(bus.WriteReg_Mem), .mem_write(bus.RegWrite_Mem), .sel(fa_p0)
  );
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rt (
    .src(bus.Rt_ID), .ex_dest(dest_p1), .ex_write(ctrl_p1.reg_write),
    .mem_dest(bus.WriteReg_Mem), .mem_write(bus.RegWrite_Mem), .sel(fb_p0)
  );

`ifdef ID_WB_BYPASS_EN
  logic wb_hit_a, wb_hit_b;
  assign wb_hit_a = bus.RegWrite_Wb & (bus.WriteReg_Wb != ZERO) & (bus.WriteReg_Wb == bus.Rs_ID);
  assign wb_hit_b = bus.RegWrite_Wb & (bus.WriteReg_Wb != ZERO) & (bus.WriteReg_Wb == bus.Rt_ID);
  assign op_a_p0  = wb_hit_a ? bus.WriteData_Reg : bus.DataOne_ID;
  assign op_b_p0  = wb_hit_b ? bus.WriteData_Reg : bus.DataTwo_ID;
`else
  // Register file writes in the first half-cycle, so read data is already current.
  logic unused_wb;
  assign unused_wb = ^{bus.WriteData_Reg, bus.RegWrite_Wb, bus.WriteReg_Wb};
  assign op_a_p0   = bus.DataOne_ID;
  assign op_b_p0   = bus.DataTwo_ID;
`endif

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p1 <= '0;
      alu_p1  <= '0;
      dest_p1 <= '0;
      fa_p1   <= FWD_REG;
      fb_p1   <= FWD_REG;
      vld_p1  <= 1'b0;
    end else if (bubble) begin
      ctrl_p1 <= '0;
      alu_p1  <= '0;
      dest_p1 <= '0;
      fa_p1   <= FWD_REG;
      fb_p1   <= FWD_REG;
      vld_p1  <= 1'b0;
    end else begin
      ctrl_p1 <= ctrl_p0;
      alu_p1  <= bus.ALUControl_ID;
      dest_p1 <= dest_p0;
      fa_p1   <= fa_p0;
      fb_p1   <= fb_p0;
      vld_p1  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_p1 <= '0;
      op_b_p1 <= '0;
      imm_p1  <= '0;
    end else begin
      op_a_p1 <= op_a_p0;
      op_b_p1 <= op_b_p0;
      imm_p1  <= bus.Imm_ID;
    end
  end

  assign bus.DataOne_Ex    = op_a_p1;
  assign bus.DataTwo_Ex    = op_b_p1;
  assign bus.Imm_Ex        = imm_p1;
  assign bus.WriteReg_Ex   = dest_p1;
  assign bus.RegWrite_Ex   = ctrl_p1.reg_write;
  assign bus.MemtoReg_Ex   = ctrl_p1.mem_to_reg;
  assign bus.MemRead_Ex    = ctrl_p1.mem_read;
  assign bus.MemWrite_Ex   = ctrl_p1.mem_write;
  assign bus.ALUSrc_Ex     = ctrl_p1.alu_src;
  assign bus.ALUControl_Ex = alu_p1;
  assign bus.FA            = fa_p1;
  assign bus.FB            = fb_p1;
  assign bus.Valid_Ex      = vld_p1;
  assign bus.stall_o       = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline sequences from a vector table plus
// randomized traffic checked against a behavioural model of the EX register.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .ALUCTL_W(3)) bus ();
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUCTL_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        regdst, rw, m2r, mr, mw, als, usesrt, flush;
    logic [2:0]  alu;
    logic [31:0] d1, d2, imm;
    logic        rw_mem;
    logic [4:0]  wr_mem;
    logic        rw_wb;
    logic [4:0]  wr_wb;
    logic [31:0] wdata;
  } in_t;

  typedef struct {
    logic        v, rw, m2r, mr, mw, als;
    logic [2:0]  alu;
    logic [4:0]  wreg;
    logic [1:0]  fa, fb;
    logic [31:0] d1, d2, imm;
  } ex_t;

  typedef struct {
    bit         do_rst;
    int         rs, rt, rd;
    bit         regdst, rw, mr, usesrt, flush;
    bit         est;
    logic [1:0] efa, efb;
    bit         ev;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  ex_t  mdl;
  bit   trk;
  logic mem_rw, wb_rw;
  logic [4:0] mem_wr, wb_wr;

  // Reference: what the EX register should hold, written straight from the hazard rules.
  function automatic logic [1:0] ref_fwd(logic [4:0] s, ex_t ex, logic mwr, logic [4:0] mdst);
    if (s == 5'd0) return 2'b00;
    if (ex.rw && ex.wreg == s) return 2'b10;
    if (mwr && mdst == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_stall(ex_t ex, in_t in);
    return ex.v && ex.mr && (ex.wreg != 5'd0) &&
           ((ex.wreg == in.rs) || (in.usesrt && ex.wreg == in.rt));
  endfunction

  function automatic ex_t ref_next(ex_t ex, in_t in);
    ex_t n = '{default: '0};
    if (in.flush || ref_stall(ex, in)) return n;
    n.v = 1'b1; n.rw = in.rw; n.m2r = in.m2r; n.mr = in.mr; n.mw = in.mw; n.als = in.als;
    n.alu = in.alu;
    n.wreg = in.regdst ? in.rd : in.rt;
    n.fa = ref_fwd(in.rs, ex, in.rw_mem, in.wr_mem);
    n.fb = ref_fwd(in.rt, ex, in.rw_mem, in.wr_mem);
    n.d1 = in.d1; n.d2 = in.d2; n.imm = in.imm;
`ifdef ID_WB_BYPASS_EN
    if (in.rw_wb && in.wr_wb != 5'd0 && in.wr_wb == in.rs) n.d1 = in.wdata;
    if (in.rw_wb && in.wr_wb != 5'd0 && in.wr_wb == in.rt) n.d2 = in.wdata;
`endif
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Valid_Ex"},      32'(bus.Valid_Ex),      32'(mdl.v));
    chk({tag, ".RegWrite_Ex"},   32'(bus.RegWrite_Ex),   32'(mdl.rw));
    chk({tag, ".MemtoReg_Ex"},   32'(bus.MemtoReg_Ex),   32'(mdl.m2r));
    chk({tag, ".MemRead_Ex"},    32'(bus.MemRead_Ex),    32'(mdl.mr));
    chk({tag, ".MemWrite_Ex"},   32'(bus.MemWrite_Ex),   32'(mdl.mw));
    chk({tag, ".ALUSrc_Ex"},     32'(bus.ALUSrc_Ex),     32'(mdl.als));
    chk({tag, ".ALUControl_Ex"}, 32'(bus.ALUControl_Ex), 32'(mdl.alu));
    chk({tag, ".WriteReg_Ex"},   32'(bus.WriteReg_Ex),   32'(mdl.wreg));
    chk({tag, ".FA"},            32'(bus.FA),            32'(mdl.fa));
    chk({tag, ".FB"},            32'(bus.FB),            32'(mdl.fb));
    if (mdl.v) begin
      chk({tag, ".DataOne_Ex"}, bus.DataOne_Ex, mdl.d1);
      chk({tag, ".DataTwo_Ex"}, bus.DataTwo_Ex, mdl.d2);
      chk({tag, ".Imm_Ex"},     bus.Imm_Ex,     mdl.imm);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".Valid_Ex"},      32'(bus.Valid_Ex), 0);
    chk({tag, ".ctrl"},          32'({bus.RegWrite_Ex, bus.MemtoReg_Ex, bus.MemRead_Ex,
                                      bus.MemWrite_Ex, bus.ALUSrc_Ex}), 0);
    chk({tag, ".ALUControl_Ex"}, 32'(bus.ALUControl_Ex), 0);
    chk({tag, ".WriteReg_Ex"},   32'(bus.WriteReg_Ex), 0);
    chk({tag, ".FA_FB"},         32'({bus.FA, bus.FB}), 0);
    chk({tag, ".DataOne_Ex"},    bus.DataOne_Ex, 0);
    chk({tag, ".DataTwo_Ex"},    bus.DataTwo_Ex, 0);
    chk({tag, ".Imm_Ex"},        bus.Imm_Ex, 0);
    chk({tag, ".stall_o"},       32'(bus.stall_o), 0);
  endtask

  task automatic drive(input in_t in);
    bus.flush_i = in.flush;       bus.DataOne_ID = in.d1;     bus.DataTwo_ID = in.d2;
    bus.Imm_ID = in.imm;          bus.Rs_ID = in.rs;          bus.Rt_ID = in.rt;
    bus.Rd_ID = in.rd;            bus.UsesRt_ID = in.usesrt;  bus.RegWrite_ID = in.rw;
    bus.MemtoReg_ID = in.m2r;     bus.MemRead_ID = in.mr;     bus.MemWrite_ID = in.mw;
    bus.ALUSrc_ID = in.als;       bus.RegDst_ID = in.regdst;  bus.ALUControl_ID = in.alu;
    bus.RegWrite_Mem = in.rw_mem; bus.WriteReg_Mem = in.wr_mem;
    bus.RegWrite_Wb = in.rw_wb;   bus.WriteReg_Wb = in.wr_wb; bus.WriteData_Reg = in.wdata;
  endtask

  function automatic in_t mk(int rs, int rt, int rd, bit regdst, bit rw, bit mr, bit usesrt, bit flush);
    in_t in;
    in.rs = 5'(rs); in.rt = 5'(rt); in.rd = 5'(rd);
    in.regdst = regdst; in.rw = rw; in.m2r = mr; in.mr = mr; in.mw = 1'b0;
    in.als = ~regdst; in.usesrt = usesrt; in.flush = flush;
    in.alu = 3'($urandom); in.d1 = $urandom; in.d2 = $urandom; in.imm = $urandom;
    in.rw_mem = 1'b0; in.wr_mem = '0; in.rw_wb = 1'b0; in.wr_wb = '0; in.wdata = $urandom;
    return in;
  endfunction

  function automatic vec_t mv(bit r, int rs, int rt, int rd, bit regdst, bit rw, bit mr,
                              bit usesrt, bit flush, bit est, logic [1:0] efa,
                              logic [1:0] efb, bit ev);
    vec_t v;
    v.do_rst = r; v.rs = rs; v.rt = rt; v.rd = rd; v.regdst = regdst; v.rw = rw; v.mr = mr;
    v.usesrt = usesrt; v.flush = flush; v.est = est; v.efa = efa; v.efb = efb; v.ev = ev;
    return v;
  endfunction

  task automatic model_reset();
    mdl = '{default: '0};
    mem_rw = 1'b0; mem_wr = '0; wb_rw = 1'b0; wb_wr = '0;
  endtask

  // Called at posedge+1; returns at the following posedge+1 with outputs checked.
  task automatic step(input in_t in_arg, input string tag, output logic st_seen);
    in_t in;
    ex_t nxt;
    in = in_arg;
    if (trk) begin
      in.rw_mem = mem_rw; in.wr_mem = mem_wr; in.rw_wb = wb_rw; in.wr_wb = wb_wr;
    end
    drive(in);
    @(negedge clk);
    st_seen = bus.stall_o;
    chk({tag, ".stall_o"}, 32'(bus.stall_o), 32'(ref_stall(mdl, in)));
    nxt = ref_next(mdl, in);
    @(posedge clk);
    #1;
    wb_rw = mem_rw; wb_wr = mem_wr;
    mem_rw = mdl.rw; mem_wr = mdl.wreg;
    mdl = nxt;
    check_all(tag);
  endtask

  vec_t tbl[$];
  logic st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t in;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_zero("reset");
    rst = 1'b0;
    trk = 1'b1;

    // add $3,$1,$2 loaded, then reset asserted mid-cycle clears everything at once
    step(mk(1, 2, 3, 1, 1, 0, 1, 0), "t1_add", st);
    #2 rst = 1'b1;
    #1 check_zero("t1_midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // rst, rs, rt, rd, regdst, rw, mr, usesrt, flush | stall, FA, FB, Valid
    tbl.push_back(mv(1, 1, 2, 3, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // add $3,$1,$2
    tbl.push_back(mv(0, 3, 5, 4, 1, 1, 0, 1, 0, 0, 2'b10, 2'b00, 1)); // sub $4,$3,$5
    tbl.push_back(mv(1, 1, 2, 3, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // add $3
    tbl.push_back(mv(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // nop
    tbl.push_back(mv(0, 3, 3, 4, 1, 1, 0, 1, 0, 0, 2'b01, 2'b01, 1)); // sub $4,$3,$3
    tbl.push_back(mv(1, 1, 2, 3, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // add $3
    tbl.push_back(mv(0, 1, 1, 3, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // add $3,$1,$1
    tbl.push_back(mv(0, 3, 3, 4, 1, 1, 0, 1, 0, 0, 2'b10, 2'b10, 1)); // EX beats MEM
    tbl.push_back(mv(1, 1, 3, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // lw $3,0($1)
    tbl.push_back(mv(0, 3, 2, 4, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00, 0)); // add stalls
    tbl.push_back(mv(0, 3, 2, 4, 1, 1, 0, 1, 0, 0, 2'b01, 2'b00, 1)); // add enters
    tbl.push_back(mv(1, 1, 2, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // add $0
    tbl.push_back(mv(0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // sub $4,$0,$0
    tbl.push_back(mv(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // lw $0
    tbl.push_back(mv(0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1)); // use $0: no stall
    tbl.push_back(mv(1, 1, 3, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // lw $3
    tbl.push_back(mv(0, 3, 2, 4, 1, 1, 0, 1, 1, 1, 2'b00, 2'b00, 0)); // flush + stall
    tbl.push_back(mv(0, 3, 2, 4, 1, 1, 0, 1, 0, 0, 2'b01, 2'b00, 1)); // refetched add
    tbl.push_back(mv(1, 1, 3, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // lw $3
    tbl.push_back(mv(0, 1, 3, 5, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 1)); // rt not a source

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].do_rst) begin
        rst = 1'b1; #1 rst = 1'b0;
        model_reset();
      end
      step(mk(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].regdst, tbl[i].rw, tbl[i].mr,
              tbl[i].usesrt, tbl[i].flush), tag, st);
      chk({tag, ".tbl_stall"}, 32'(st), 32'(tbl[i].est));
      chk({tag, ".tbl_FA"},    32'(bus.FA), 32'(tbl[i].efa));
      chk({tag, ".tbl_FB"},    32'(bus.FB), 32'(tbl[i].efb));
      chk({tag, ".tbl_Valid"}, 32'(bus.Valid_Ex), 32'(tbl[i].ev));
    end

`ifdef ID_WB_BYPASS_EN
    trk = 1'b0;
    in = mk(7, 7, 9, 1, 1, 0, 1, 0);
    in.d1 = 32'h1234_5678; in.d2 = 32'h0BAD_F00D;
    in.rw_wb = 1'b1; in.wr_wb = 5'd7; in.wdata = 32'hDEAD_BEEF;
    step(in, "bypass", st);
    chk("bypass.DataOne", bus.DataOne_Ex, 32'hDEAD_BEEF);
    chk("bypass.DataTwo", bus.DataTwo_Ex, 32'hDEAD_BEEF);
`endif

    trk = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3), 1'($urandom),
              ($urandom_range(0, 9) == 0));
      in.m2r = 1'($urandom); in.mw = 1'($urandom); in.als = 1'($urandom);
      in.rw_mem = 1'($urandom); in.wr_mem = 5'($urandom_range(0, 7));
      in.rw_wb = 1'($urandom);  in.wr_wb = 5'($urandom_range(0, 7));
      step(in, "rnd", st);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
